sram_1w1r_fifo_ctrl: RTL

SRAM_1W1R_FIFO_CTRL -- requirements
Module: sram_1w1r_fifo_ctrl

---
 rtl/sram_1w1r_fifo_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_1w1r_fifo_ctrl.sv
// FIFO controller around a 1W1R SRAM macro with a registered read port and a 2-entry output buffer.
// Optional registered almost_full watermark: define SRAM_FIFO_WATERMARK_EN.
module sram_1w1r_fifo_ctrl #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_DIFF = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    if (AF_THRESH < 1 || AF_THRESH > RAM_DEPTH + 2) begin : g_bad_af_thresh
        $error("AF_THRESH out of range");
    end

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_inflight;
    logic [1:0]            r_obuf_cnt;
    logic [DATA_WIDTH-1:0] r_obuf0;
    logic [DATA_WIDTH-1:0] r_obuf1;

    logic [ADDR_WIDTH:0]   w_diff;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_occ;
    logic [1:0]            w_cnt_after_pop;
    logic [1:0]            w_obuf_cnt_next;
    logic [DATA_WIDTH-1:0] w_obuf0_next;
    logic [DATA_WIDTH-1:0] w_obuf1_next;

    assign w_diff     = r_wr_ptr - r_rd_ptr;
    assign push_ready = (w_diff != FULL_DIFF);
    assign w_push     = rst_n & push_valid & push_ready;
    assign pop_valid  = (r_obuf_cnt != 2'd0);
    assign pop_data   = r_obuf0;
    assign w_pop      = pop_valid & pop_ready;

    // Buffer slots committed after this cycle: entries kept past the pop plus the read landing now.
    assign w_occ   = r_obuf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = rst_n & (r_wr_ptr != r_rd_ptr) & (w_occ < 2'd2);

    assign sram_csb0  = ~w_push;
    assign sram_addr0 = w_push ? r_wr_ptr[ADDR_WIDTH-1:0] : '0;
    assign sram_din0  = w_push ? push_data : '0;
    assign sram_csb1  = ~w_issue;
    assign sram_addr1 = w_issue ? r_rd_ptr[ADDR_WIDTH-1:0] : '0;

    assign level = {1'b0, w_diff}
                 + {{(ADDR_WIDTH + 1){1'b0}}, r_inflight}
                 + {{ADDR_WIDTH{1'b0}}, r_obuf_cnt};

    always_comb begin
        w_obuf0_next    = r_obuf0;
        w_obuf1_next    = r_obuf1;
        w_cnt_after_pop = r_obuf_cnt;
        if (w_pop) begin
            w_obuf0_next    = r_obuf1;
            w_cnt_after_pop = r_obuf_cnt - 2'd1;
        end
        w_obuf_cnt_next = w_cnt_after_pop;
        // Data read in the previous cycle is valid on sram_dout1 now; append it behind survivors.
        if (r_inflight) begin
            if (w_cnt_after_pop == 2'd0) begin
                w_obuf0_next = sram_dout1;
            end else begin
                w_obuf1_next = sram_dout1;
            end
            w_obuf_cnt_next = w_cnt_after_pop + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
            r_obuf0    <= '0;
            r_obuf1    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_inflight <= w_issue;
            r_obuf_cnt <= w_obuf_cnt_next;
            r_obuf0    <= w_obuf0_next;
            r_obuf1    <= w_obuf1_next;
        end
    end

`ifdef SRAM_FIFO_WATERMARK_EN
    localparam logic [ADDR_WIDTH+1:0] AF_LEVEL = (ADDR_WIDTH + 2)'(AF_THRESH);
    logic r_almost_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (level >= AF_LEVEL);
        end
    end
    assign almost_full = r_almost_full;
`else
    assign almost_full = 1'b0;
`endif

endmodule
